pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Front-end PC controller for the 5-stage RISC-V pipeline. Owns the PCF register.
//  Arbitrates the redirect sources: Branch and Jalr resolved in EX, Jal resolved in ID.
//  Also handles load-use stalls and I-memory wait states.
//  Drives the stall/flush controls for the IF/ID/EX pipeline registers.
//  A redirect that arrives while fetch is stalled on I-mem is buffered and applied on resume.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PCF value loaded on reset
// PORTS
//  CPU_CLK        in   1   single clock, rising edge
//  CPU_RST_N      in   1   synchronous reset, active-low
//  BranchE        in   1   EX branch resolved taken
//  BranchTarget   in   32  EX branch target
//  JalrE          in   1   EX jalr
//  JalrTarget     in   32  EX jalr target (bit0 already cleared)
//  JalD           in   1   ID jal
//  JalTarget      in   32  ID jal target
//  LoadUseHazard  in   1   ID instr needs a load result still in EX
//  IMemReady      in   1   1 = instruction at PCF available this cycle; 0 = I-mem wait
//  PCF            out  32  registered fetch PC
//  StallF         out  1   hold IF (comb)
//  StallD         out  1   hold IF/ID register (comb)
//  FlushD         out  1   clear IF/ID register (comb)
//  FlushE         out  1   clear ID/EX register (comb)
//  RedirPending   out  1   a buffered redirect awaits fetch resume (registered)
// BEHAVIOUR
//  Reset (CPU_RST_N=0 at edge)
//   - PCF=RESET_PC, state=RUN, pend_tgt=0, pend_src=NONE, RedirPending=0.
//   - While CPU_RST_N=0: FlushD=FlushE=1, StallF=StallD=0.
//   - Reset mid-miss or mid-pending discards the buffered target.
//  Priority: E redirect (BranchE, then JalrE) > JalD > LoadUseHazard > sequential.
//   - BranchE & JalrE together is illegal; BranchE wins.
//  FSM states: RUN, MISS, MISS_REDIR.
//  RUN, IMemReady=1 -> next PCF:
//   - E redirect: PCF<=BranchTarget/JalrTarget; FlushD=FlushE=1. Load-use in the same cycle is ignored.
//   - JalD: PCF<=JalTarget; FlushD=1.
//   - LoadUseHazard: PCF held; StallF=StallD=1; FlushE=1.
//   - otherwise: PCF<=PCF+4 (mod 2^32, wraps 32'hFFFF_FFFC->0).
//  RUN, IMemReady=0:
//   - StallF=StallD=1, FlushE=1 (bubble into EX).
//   - With E redirect: also FlushD=1; pend_tgt<=target, pend_src<=E, go MISS_REDIR.
//   - With JalD: pend_tgt<=JalTarget, pend_src<=D, go MISS_REDIR.
//   - Otherwise go MISS.
//  MISS: same redirect capture rules as RUN with IMemReady=0.
//   - IMemReady=1 with no redirect -> RUN. Next-PC rules of RUN apply that cycle.
//  MISS_REDIR: StallF=StallD=1, FlushE=1; RedirPending=1.
//   - New E redirect overwrites pend (src=E).
//   - JalD overwrites only when pend_src=D (re-asserted JalD is idempotent).
//   - IMemReady=1: PCF<=pend_tgt, FlushD=1 (returned word is wrong-path), StallF=StallD=0.
//     Clear pend, go RUN. An E redirect in this same cycle takes precedence over pend_tgt.
//  Latency: redirect to new PCF = 1 cycle in RUN; 1 cycle after IMemReady rises otherwise.
//  StallD and FlushD are never both 1; FlushD wins.
// TESTING
//  - Reset: hold CPU_RST_N=0 2 cycles, release -> PCF=0, 0x4, 0x8 on successive cycles (IMemReady=1).
//  - PCF=0x100, BranchE=1, BranchTarget=0x200, JalD=1, JalTarget=0x300 same cycle
//    -> next PCF=0x200, FlushD=FlushE=1.
//  - PCF=0x40, LoadUseHazard=1 for 1 cycle -> StallF=StallD=FlushE=1, PCF stays 0x40, then 0x44.
//  - PCF=0x80, IMemReady=0 for 3 cycles, JalrE=1 (JalrTarget=0x400) in 1st wait cycle
//    -> RedirPending=1, PCF stays 0x80. On IMemReady=1: FlushD=1, next PCF=0x400, RedirPending=0.
//  - In MISS_REDIR with pend_src=E (0x400), JalD=1 (0x500) -> ignored, resume to 0x400.
//    Then BranchE=1 (0x600) -> resume to 0x600.
//  - PCF=0xFFFF_FFFC, sequential -> PCF=0x0. Assert CPU_RST_N=0 during MISS_REDIR
//    -> PCF=RESET_PC, RedirPending=0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Front-end PC controller: owns PCF, arbitrates EX/ID redirects, load-use stalls
// and I-memory wait states, and buffers a redirect that arrives during a fetch wait.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        JalrE,
  input  logic [31:0] JalrTarget,
  input  logic        JalD,
  input  logic [31:0] JalTarget,
  input  logic        LoadUseHazard,
  input  logic        IMemReady,
  output logic [31:0] PCF,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        RedirPending
);

  typedef enum logic [1:0] {RUN, MISS, MISS_REDIR} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_E, SRC_D} src_e;

  state_e      state_q, state_d;
  src_e        pend_src_q, pend_src_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        redir_pending_q, redir_pending_d;

  logic        e_redir;
  logic [31:0] e_tgt;
  logic        stall_f, stall_d_raw, flush_d, flush_e;

  // BranchE wins over the (illegal) simultaneous JalrE
  assign e_redir = BranchE | JalrE;
  assign e_tgt   = BranchE ? BranchTarget : JalrTarget;

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      state_q         <= RUN;
      pcf_q           <= RESET_PC;
      pend_tgt_q      <= '0;
      pend_src_q      <= SRC_NONE;
      redir_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pcf_q           <= pcf_d;
      pend_tgt_q      <= pend_tgt_d;
      pend_src_q      <= pend_src_d;
      redir_pending_q <= redir_pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    pend_tgt_d = pend_tgt_q;
    pend_src_d = pend_src_q;
    unique case (state_q)
      RUN, MISS: begin
        if (IMemReady) begin
          state_d = RUN;
          if (e_redir)             pcf_d = e_tgt;
          else if (JalD)           pcf_d = JalTarget;
          else if (!LoadUseHazard) pcf_d = pcf_q + 32'd4;
        end else if (e_redir) begin
          pend_tgt_d = e_tgt;
          pend_src_d = SRC_E;
          state_d    = MISS_REDIR;
        end else if (JalD) begin
          pend_tgt_d = JalTarget;
          pend_src_d = SRC_D;
          state_d    = MISS_REDIR;
        end else begin
          state_d = MISS;
        end
      end
      MISS_REDIR: begin
        if (IMemReady) begin
          pcf_d      = e_redir ? e_tgt : pend_tgt_q;
          pend_tgt_d = '0;
          pend_src_d = SRC_NONE;
          state_d    = RUN;
        end else if (e_redir) begin
          pend_tgt_d = e_tgt;
          pend_src_d = SRC_E;
        end else if (JalD && pend_src_q == SRC_D) begin
          pend_tgt_d = JalTarget;
        end
      end
      default: state_d = RUN;
    endcase
    redir_pending_d = (state_d == MISS_REDIR);
  end

  always_comb begin
    stall_f     = 1'b0;
    stall_d_raw = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    if (!CPU_RST_N) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      unique case (state_q)
        RUN, MISS: begin
          if (IMemReady) begin
            if (e_redir) begin
              flush_d = 1'b1;
              flush_e = 1'b1;
            end else if (JalD) begin
              flush_d = 1'b1;
            end else if (LoadUseHazard) begin
              stall_f     = 1'b1;
              stall_d_raw = 1'b1;
              flush_e     = 1'b1;
            end
          end else begin
            stall_f     = 1'b1;
            stall_d_raw = 1'b1;
            flush_e     = 1'b1;
            flush_d     = e_redir;
          end
        end
        MISS_REDIR: begin
          flush_e = 1'b1;
          if (IMemReady) begin
            flush_d = 1'b1;
          end else begin
            stall_f     = 1'b1;
            stall_d_raw = 1'b1;
            flush_d     = e_redir;
          end
        end
        default: ;
      endcase
    end
  end

  assign PCF          = pcf_q;
  assign StallF       = stall_f;
  assign StallD       = stall_d_raw & ~flush_d;
  assign FlushD       = flush_d;
  assign FlushE       = flush_e;
  assign RedirPending = redir_pending_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed vector table plus a modelled sequential/load-use run.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br, jr, jd, luh, rdy;
  logic [31:0] bt, jt, jdt;
  logic [31:0] pcf;
  logic        stall_f, stall_d, flush_d, flush_e, redir_pending;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .CPU_CLK      (clk),
    .CPU_RST_N    (rst_n),
    .BranchE      (br),
    .BranchTarget (bt),
    .JalrE        (jr),
    .JalrTarget   (jt),
    .JalD         (jd),
    .JalTarget    (jdt),
    .LoadUseHazard(luh),
    .IMemReady    (rdy),
    .PCF          (pcf),
    .StallF       (stall_f),
    .StallD       (stall_d),
    .FlushD       (flush_d),
    .FlushE       (flush_e),
    .RedirPending (redir_pending)
  );

  typedef struct {
    logic        rst_n, br;
    logic [31:0] bt;
    logic        jr;
    logic [31:0] jt;
    logic        jd;
    logic [31:0] jdt;
    logic        luh, rdy;
    logic [31:0] e_pcf;
    logic        e_rp;
    logic [3:0]  e_ctl; // {StallF, StallD, FlushD, FlushE}
  } vec_t;

  typedef struct {
    logic [31:0] pcf;
    logic        rp;
    logic [3:0]  ctl;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic b, input logic [31:0] b_t,
                     input logic j, input logic [31:0] j_t,
                     input logic d, input logic [31:0] d_t,
                     input logic l, input logic y,
                     input logic [31:0] ep, input logic erp, input logic [3:0] ec);
    vec_t v;
    v.rst_n = r; v.br = b; v.bt = b_t; v.jr = j; v.jt = j_t;
    v.jd = d; v.jdt = d_t; v.luh = l; v.rdy = y;
    v.e_pcf = ep; v.e_rp = erp; v.e_ctl = ec;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; br = v.br; bt = v.bt; jr = v.jr; jt = v.jt;
    jd = v.jd; jdt = v.jdt; luh = v.luh; rdy = v.rdy;
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries, required at least 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    if ({pcf, redir_pending, stall_f, stall_d, flush_d, flush_e} !== {e.pcf, e.rp, e.ctl}) begin
      failures++;
      $display("FAIL %s: got pcf=%h rp=%b sf/sd/fd/fe=%b%b%b%b, required pcf=%h rp=%b sf/sd/fd/fe=%b",
               e.name, pcf, redir_pending, stall_f, stall_d, flush_d, flush_e, e.pcf, e.rp, e.ctl);
    end
  endtask

  initial begin
    logic [31:0] pc_m;
    logic        l;
    exp_t        e;

    rst_n = 1'b0; br = 1'b0; jr = 1'b0; jd = 1'b0; luh = 1'b0; rdy = 1'b1;
    bt = '0; jt = '0; jdt = '0;
    @(posedge clk);

    //   rst br bt        jr jt        jd jdt          luh rdy  pcf           rp ctl
    add(0, 1, 32'h0,     0, 32'h0,     0, 32'h0,        0,  0,  32'h0,        0, 4'b0011); // reset overrides
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h0,        0, 4'b0000);
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h4,        0, 4'b0000);
    add(1, 0, 32'h0,     0, 32'h0,     1, 32'h100,      0,  1,  32'h8,        0, 4'b0010); // jal
    add(1, 1, 32'h200,   0, 32'h0,     1, 32'h300,      0,  1,  32'h100,      0, 4'b0011); // E beats D
    add(1, 0, 32'h0,     0, 32'h0,     1, 32'h40,       0,  1,  32'h200,      0, 4'b0010);
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1,  1,  32'h40,       0, 4'b1101); // load-use
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h40,       0, 4'b0000);
    add(1, 0, 32'h0,     1, 32'h80,    0, 32'h0,        1,  1,  32'h44,       0, 4'b0011); // jalr, luh ignored
    add(1, 0, 32'h0,     1, 32'h400,   0, 32'h0,        0,  0,  32'h80,       0, 4'b1011); // capture E
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  0,  32'h80,       1, 4'b1101);
    add(1, 0, 32'h0,     0, 32'h0,     1, 32'h500,      0,  0,  32'h80,       1, 4'b1101); // D ignored
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h80,       1, 4'b0011); // resume
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h400,      0, 4'b0000);
    add(1, 0, 32'h0,     0, 32'h0,     1, 32'h500,      0,  0,  32'h404,      0, 4'b1101); // capture D
    add(1, 0, 32'h0,     0, 32'h0,     1, 32'h520,      0,  0,  32'h404,      1, 4'b1101); // D over D
    add(1, 1, 32'h600,   0, 32'h0,     0, 32'h0,        0,  0,  32'h404,      1, 4'b1011); // E over D
    add(1, 0, 32'h0,     0, 32'h0,     1, 32'h700,      0,  0,  32'h404,      1, 4'b1101);
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h404,      1, 4'b0011);
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h600,      0, 4'b0000);
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1,  0,  32'h604,      0, 4'b1101); // plain miss
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        1,  1,  32'h604,      0, 4'b1101); // resume + luh
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  0,  32'h604,      0, 4'b1101);
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h604,      0, 4'b0000);
    add(1, 0, 32'h0,     0, 32'h0,     1, 32'h800,      0,  0,  32'h608,      0, 4'b1101);
    add(1, 1, 32'h900,   0, 32'h0,     0, 32'h0,        0,  1,  32'h608,      1, 4'b0011); // E beats pend
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h900,      0, 4'b0000);
    add(1, 0, 32'h0,     0, 32'h0,     1, 32'hFFFF_FFF8, 0,  1,  32'h904,      0, 4'b0010);
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'hFFFF_FFF8, 0, 4'b0000);
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'hFFFF_FFFC, 0, 4'b0000); // wrap
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h0,        0, 4'b0000);
    add(1, 0, 32'h0,     1, 32'hA00,   0, 32'h0,        0,  0,  32'h4,        0, 4'b1011);
    add(0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  0,  32'h4,        1, 4'b0011); // reset in MISS_REDIR
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h0,        0, 4'b0000);
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h4,        0, 4'b0000); // pend discarded
    add(1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        0,  1,  32'h8,        0, 4'b0000);

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      e.pcf = vecs[i].e_pcf; e.rp = vecs[i].e_rp; e.ctl = vecs[i].e_ctl;
      e.name = $sformatf("vec%0d", i);
      sb.push_back(e);
      #1 check_out();
    end

    pc_m = 32'hC;
    for (int unsigned k = 0; k < 16; k++) begin
      @(negedge clk);
      l = 1'($urandom_range(0, 1));
      rst_n = 1'b1; br = 1'b0; jr = 1'b0; jd = 1'b0; rdy = 1'b1; luh = l;
      e.pcf = pc_m; e.rp = 1'b0; e.ctl = {l, l, 1'b0, l};
      e.name = $sformatf("seq%0d", k);
      sb.push_back(e);
      #1 check_out();
      if (!l) pc_m = pc_m + 32'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
